accumulator_ctrl: RTL and testbench
===================================

# accumulator_ctrl

Sequencer for the partial-sum Accumulator in normal (non-test) mode. It generates the row-0 write enable and write address while the systolic array streams partial sums, waits for the per-column write skew to drain, then reads every written row back through the outside read port under a valid/ready handshake. It sits between the array-control logic and the output/activation stage, and idles whenever BIST owns the accumulator.

## Interface
- SYSTOLIC_SIZE, 8, array dimension and accumulator column count; must be ≥2
- PATTERN_NUMBER, 1, patterns per tile
- DEPTH, PATTERN_NUMBER*SYSTOLIC_SIZE, accumulator rows
- ADDR_WIDTH, $clog2(DEPTH), row address width
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- test_mode  in  1  BIST owns the accumulator; controller forced idle
- start  in  1  one-cycle tile start request
- num_rows  in  ADDR_WIDTH+1  rows in this tile, sampled on accepted start
- psum_valid  in  1  row-0 partial sum valid this cycle
- wr_en  out  1  accumulator write enable (row 0)
- wr_addr  out  ADDR_WIDTH  accumulator write address (row 0)
- rd_addr_outside  out  ADDR_WIDTH  accumulator read address
- out_valid  out  1  read data on accumulator output is valid
- out_ready  in  1  downstream accepts read data
- out_last  out  1  current read beat is the last row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on tile completion

## Operation
- States: IDLE, WRITE, DRAIN, READ, DONE.
- IDLE: start=1 and test_mode=0 → latch rows = min(num_rows, DEPTH), clear counters. rows≠0 → WRITE; rows=0 → DONE (no writes, no reads).
- WRITE: wr_en = psum_valid; wr_addr = wr_cnt. Each psum_valid cycle increments wr_cnt. The write for wr_cnt = rows-1 → DRAIN next cycle, drain_cnt cleared. Gaps in psum_valid stall with no write.
- DRAIN: SYSTOLIC_SIZE-1 cycles, no writes, so the skewed column writes complete. Then → READ with rd_cnt=0.
- READ: out_valid=1, rd_addr_outside = rd_cnt, out_last = (rd_cnt == rows-1). On out_valid&&out_ready: rd_cnt++; on the last beat → DONE. Without ready, rd_addr_outside and out_last hold. Accumulator read is combinational on the address, so the data belongs to the current rd_addr_outside.
- DONE: done=1 for one cycle → IDLE.
- start while busy: ignored. psum_valid outside WRITE: ignored, wr_en=0.
- test_mode=1 in any state: next state IDLE, counters cleared, wr_en=0, out_valid=0, done not pulsed. A tile aborted this way is lost.
- Counters: wr_cnt/rd_cnt ADDR_WIDTH+1 bits; drain_cnt $clog2(SYSTOLIC_SIZE) bits. The rows clamp guarantees no wrap.

## Timing
- Reset values: wr_en=0, wr_addr=0, rd_addr_outside=0, out_valid=0, out_last=0, busy=0, done=0; state IDLE.
- wr_en/wr_addr are combinational from state, wr_cnt and psum_valid (same-cycle write). Other outputs decode registered state and counters.
- Start accepted at cycle T → busy=1 at T+1, WRITE at T+1.
- Last write at W → DRAIN over W+1..W+SYSTOLIC_SIZE-1 → first out_valid at W+SYSTOLIC_SIZE.
- With continuous ready, one row per cycle. Last handshake at R → done=1 at R+1, busy=0 at R+2.
- rows=0: done at T+1, IDLE at T+2.
- Asynchronous reset mid-tile: immediate return to reset values.

## Structure
- accumulator_pkg: state enum, DEPTH/ADDR_WIDTH derivation function, shared with Accumulator and the BIST controller.
- Single module. Optional sub-module accumulator_row_counter: a clearable, enable-gated counter with terminal compare, instanced for the write and read counters.

## Test plan
- SIZE=8, num_rows=8, continuous psum_valid → wr_addr 0..7 on 8 consecutive cycles, 7 drain cycles, reads 0..7, out_last on addr 7, single done pulse.
- psum_valid toggling 1,0,1,0 with num_rows=4 → writes to addrs 0..3 only on valid cycles, DRAIN starts after the 4th write.
- out_ready low for 3 cycles at rd addr 2 → rd_addr_outside holds at 2, out_valid stays 1, no row skipped or repeated.
- num_rows=0 → done at T+1, wr_en and out_valid never assert. num_rows=15 with DEPTH=8 → exactly 8 writes and 8 reads.
- test_mode raised during READ → IDLE next cycle, out_valid=0, no done. A new start after test_mode falls runs normally.
- start pulsed during DRAIN → ignored, tile completes unchanged. rst_n asserted mid-WRITE → all outputs 0 immediately.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator, its sequencer and the BIST controller.
// State codes are plain constants so legacy blocks can compare against them directly.
package accumulator_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd2;
    localparam logic [STATE_W-1:0] ST_READ  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    // Row address width for a given accumulator depth; never narrower than one bit.
    function automatic int acc_addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/accumulator_row_counter.sv
// Clearable, enable-gated row counter with a terminal compare against a runtime limit.
module accumulator_row_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/accumulator_ctrl.sv
// Normal-mode accumulator sequencer: row-0 writes, skew drain, then handshaked read-back.
// Goes idle (and drops the tile) whenever test_mode hands the accumulator to BIST.
module accumulator_ctrl
    import accumulator_pkg::*;
#(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int PATTERN_NUMBER = 1,
    parameter int DEPTH          = PATTERN_NUMBER * SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH     = acc_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_mode,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_rows,
    input  logic                  psum_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr_outside,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DW = (SYSTOLIC_SIZE > 2) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SYSTOLIC_SIZE - 2);

    logic [STATE_W-1:0] state, state_nxt;
    logic [CW-1:0]      rows, rows_clamped, last_row;
    logic [CW-1:0]      wr_cnt, rd_cnt;
    logic               wr_last, rd_last;
    logic [DW-1:0]      drain_cnt;
    logic               cnt_clr, wr_fire, rd_fire, accept;

    assign rows_clamped = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
    assign last_row     = rows - CW'(1);
    assign accept       = (state == ST_IDLE) && start && !test_mode;
    assign cnt_clr      = (state == ST_IDLE) || test_mode;
    assign wr_fire      = (state == ST_WRITE) && psum_valid && !test_mode;
    assign rd_fire      = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        if (test_mode) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = (rows_clamped == '0) ? ST_DONE : ST_WRITE;
                ST_WRITE: if (wr_fire && wr_last) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_READ;
                ST_READ:  if (rd_fire && rd_last) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rows      <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                rows <= rows_clamped;
            // Counts the cycles spent in DRAIN so the column skew can settle.
            if ((state == ST_DRAIN) && !test_mode)
                drain_cnt <= drain_cnt + DW'(1);
            else
                drain_cnt <= '0;
        end
    end

    accumulator_row_counter #(.W(CW)) u_wr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (wr_fire),
        .limit    (last_row),
        .count    (wr_cnt),
        .at_limit (wr_last)
    );

    accumulator_row_counter #(.W(CW)) u_rd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (rd_fire),
        .limit    (last_row),
        .count    (rd_cnt),
        .at_limit (rd_last)
    );

    assign wr_en           = wr_fire;
    assign wr_addr         = (state == ST_WRITE) ? wr_cnt[ADDR_WIDTH-1:0] : '0;
    assign out_valid       = (state == ST_READ) && !test_mode;
    assign rd_addr_outside = (state == ST_READ) ? rd_cnt[ADDR_WIDTH-1:0] : '0;
    assign out_last        = out_valid && rd_last;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE) && !test_mode;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Scoreboard bench for accumulator_ctrl: expected write/read beats are queued as stimulus is
// driven and retired by a negedge monitor as the controller produces them.
module tb_accumulator_ctrl;

    localparam int S  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_mode;
    logic          start;
    logic [AW:0]   num_rows;
    logic          psum_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr_outside;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int wr_q[$];
    int rd_q[$];

    accumulator_ctrl #(.SYSTOLIC_SIZE(S), .PATTERN_NUMBER(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .test_mode       (test_mode),
        .start           (start),
        .num_rows        (num_rows),
        .psum_valid      (psum_valid),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .rd_addr_outside (rd_addr_outside),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    // Retire write and read beats against the scoreboard; anything unexpected is a failure.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_addr", int'(wr_addr), wr_q.pop_front());
            end
            if (out_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else if (out_ready) chk("rd_beat", int'({out_last, 5'd0, rd_addr_outside}), rd_q.pop_front());
                else chk("rd_hold", int'({out_last, 5'd0, rd_addr_outside}), rd_q[0]);
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_tile(input int n, input bit toggle, input int stall_at, input bit start_in_drain);
        int rows;
        int beat;
        int stall;
        int cyc;
        rows = (n > D) ? D : n;
        num_rows = (AW+1)'(n);
        start = 1'b1;
        wait_clk();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (rows == 0) begin
            done_exp++;
            chk("done_rows0", done, 1);
            wait_clk();
            chk("idle_rows0", busy, 0);
            chk("done_count", done_cnt, done_exp);
            return;
        end
        for (int i = 0; i < rows; i++) begin
            wr_q.push_back(i);
            psum_valid = 1'b1;
            wait_clk();
            if (toggle && i != rows - 1) begin
                psum_valid = 1'b0;
                wait_clk();
            end
        end
        psum_valid = 1'b0;
        for (int d = 0; d < S - 1; d++) begin
            if (start_in_drain && d == 2) start = 1'b1;
            if (d == 1) psum_valid = 1'b1;
            chk("drain_no_valid", out_valid, 0);
            wait_clk();
            start = 1'b0;
            psum_valid = 1'b0;
        end
        chk("first_valid", out_valid, 1);
        for (int i = 0; i < rows; i++)
            rd_q.push_back(((i == rows - 1) ? 256 : 0) + i);
        beat = 0;
        stall = 3;
        cyc = 0;
        while (beat < rows && cyc < 100) begin
            if (beat == stall_at && stall > 0) begin
                out_ready = 1'b0;
                stall--;
                chk("stall_valid", out_valid, 1);
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready && out_valid) beat++;
            wait_clk();
            cyc++;
        end
        out_ready = 1'b1;
        if (beat < rows) chk("read_timeout", beat, rows);
        if (stall_at < 0) chk("read_cycles", cyc, rows);
        done_exp++;
        chk("done_pulse", done, 1);
        wait_clk();
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("done_count", done_cnt, done_exp);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        test_mode = 1'b0;
        start = 1'b0;
        num_rows = '0;
        psum_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", int'({wr_en, wr_addr, rd_addr_outside, out_valid, out_last, busy, done}), 0);
        rst_n = 1'b1;
        wait_clk();

        run_tile(8, 1'b0, -1, 1'b0);   // full tile, continuous flow
        run_tile(4, 1'b1, -1, 1'b0);   // gapped psum_valid
        run_tile(8, 1'b0, 2, 1'b0);    // ready stall at row 2
        run_tile(0, 1'b0, -1, 1'b0);   // empty tile
        run_tile(15, 1'b0, -1, 1'b0);  // clamped to DEPTH
        run_tile(8, 1'b0, -1, 1'b1);   // start during DRAIN ignored

        // test_mode abort during READ
        num_rows = 4'd8;
        start = 1'b1;
        wait_clk();
        start = 1'b0;
        for (int i = 0; i < D; i++) begin
            wr_q.push_back(i);
            psum_valid = 1'b1;
            wait_clk();
        end
        psum_valid = 1'b0;
        repeat (S - 1) wait_clk();
        for (int i = 0; i < D; i++)
            rd_q.push_back(((i == D - 1) ? 256 : 0) + i);
        repeat (2) wait_clk();
        test_mode = 1'b1;
        wait_clk();
        test_mode = 1'b0;
        rd_q.delete();
        chk("tm_valid_low", out_valid, 0);
        chk("tm_idle", busy, 0);
        wait_clk();
        chk("tm_no_done", done_cnt, done_exp);
        run_tile(8, 1'b0, -1, 1'b0);

        // asynchronous reset mid-WRITE
        num_rows = 4'd8;
        start = 1'b1;
        wait_clk();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back(i);
            psum_valid = 1'b1;
            wait_clk();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", int'({wr_en, wr_addr, rd_addr_outside, out_valid, out_last, busy, done}), 0);
        wr_q.delete();
        psum_valid = 1'b0;
        wait_clk();
        rst_n = 1'b1;
        wait_clk();
        run_tile(5, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
